// File: rtl/demux1_8_reg_pkg.sv
// Shared sizing constants for the 1-to-8 result distribution path.
// Also used by the ALU result-select logic so both sides agree on channel count.
package demux1_8_reg_pkg;

    localparam int DEMUX_SEL_W = 3;
    localparam int DEMUX_NCH   = 8;

endpackage

// File: rtl/demux1_8_reg_decoder3_8.sv
// Purely combinational 3-to-8 one-hot decoder for the channel select.
module decoder3_8
    import demux1_8_reg_pkg::*;
(
    input  logic [DEMUX_SEL_W-1:0] sel_i,
    output logic [DEMUX_NCH-1:0]   onehot_o
);

    // NOTE: assign a default first in always_comb so no path leaves a bit unassigned (no latch).
    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/demux1_8_reg.sv
// Registered 1-to-8 demultiplexer: one input handshake, eight independently
// draining one-entry channel registers.
module demux1_8_reg
    import demux1_8_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DEMUX_SEL_W-1:0]     sel,
    output logic                       in_ready,
    output logic [DEMUX_NCH-1:0]       out_valid,
    output logic [DEMUX_NCH*WIDTH-1:0] out_data,
    input  logic [DEMUX_NCH-1:0]       out_ready
);

    logic [DEMUX_NCH-1:0] sel_onehot;
    logic [DEMUX_NCH-1:0] valid_q;
    logic [DEMUX_NCH-1:0] load;

    decoder3_8 u_decoder (
        .sel_i    (sel),
        .onehot_o (sel_onehot)
    );

    // Only the selected channel decides acceptance; other channels never stall the producer.
    assign in_ready = !valid_q[sel] | out_ready[sel];
    assign load     = sel_onehot & {DEMUX_NCH{in_valid & in_ready}};

    for (genvar g = 0; g < DEMUX_NCH; g++) begin : g_ch
        logic             valid_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        // A load wins over a drain so a draining channel can refill on the same edge.
        always_comb begin
            valid_d = valid_q[g];
            data_d  = data_q;
            if (load[g]) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_ready[g]) begin
                valid_d = 1'b0;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q[g] <= 1'b0;
                data_q     <= '0;
            end else begin
                valid_q[g] <= valid_d;
                data_q     <= data_d;
            end
        end

        assign out_data[g*WIDTH +: WIDTH] = data_q;
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux1_8_reg.sv
// Scoreboard bench for demux1_8_reg: directed scenarios plus a random soak.
module tb_demux1_8_reg;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [2:0]  sel;
    logic        in_ready;
    logic [7:0]  out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_ready;

    int checks;
    int errors;

    logic [7:0] sb_q [8][$];
    logic [7:0] last_data [8];
    logic [7:0] mon_ev;
    logic       mon_er;
    logic       stall;
    int         left;

    demux1_8_reg #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sel       (sel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d);
        @(posedge clock);
        #1;
        in_valid = v;
        sel      = s;
        in_data  = d;
    endtask

    // Monitor: holds the expected per-channel contents and checks every cycle.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                sb_q[i].delete();
                last_data[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) mon_ev[i] = (sb_q[i].size() != 0);
            check("out_valid", {56'd0, out_valid}, {56'd0, mon_ev});
            mon_er = !mon_ev[sel] || out_ready[sel];
            check("in_ready", {63'd0, in_ready}, {63'd0, mon_er});
            for (int i = 0; i < 8; i++) begin
                check("out_data_hold", {56'd0, out_data[i*8 +: 8]}, {56'd0, last_data[i]});
                if (mon_ev[i] && out_ready[i])
                    check("drain_word", {56'd0, out_data[i*8 +: 8]}, {56'd0, sb_q[i].pop_front()});
            end
            if (in_valid && mon_er) begin
                sb_q[sel].push_back(in_data);
                last_data[sel] = in_data;
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sel       = 3'd0;
        out_ready = 8'h00;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_valid", {56'd0, out_valid}, 64'h0);
        check("reset_data", out_data, 64'h0);
        check("reset_ready", {63'd0, in_ready}, 64'h1);

        // Reset while channels 2 and 5 hold words.
        drive(1'b1, 3'd2, 8'h77);
        drive(1'b1, 3'd5, 8'h55);
        drive(1'b0, 3'd0, 8'h00);
        check("pre_reset_valid", {56'd0, out_valid}, 64'h24);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", {56'd0, out_valid}, 64'h0);
        check("async_reset_data", out_data, 64'h0);
        check("in_reset_ready", {63'd0, in_ready}, 64'h1);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check("post_reset_ready", {63'd0, in_ready}, 64'h1);

        // Single route to channel 3 with the consumer stalled.
        drive(1'b1, 3'd3, 8'hA5);
        drive(1'b0, 3'd0, 8'h00);
        check("route_valid", {56'd0, out_valid}, 64'h08);
        check("route_data", {56'd0, out_data[31:24]}, 64'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("route_hold_valid", {56'd0, out_valid}, 64'h08);
            check("route_hold_data", {56'd0, out_data[31:24]}, 64'hA5);
        end

        // Backpressure on the full channel, then release.
        drive(1'b1, 3'd3, 8'h3C);
        #1 check("bp_ready", {63'd0, in_ready}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ready_hold", {63'd0, in_ready}, 64'h0);
            check("bp_data_hold", {56'd0, out_data[31:24]}, 64'hA5);
        end
        @(posedge clock);
        #1 out_ready = 8'h08;
        #1 check("bp_release_ready", {63'd0, in_ready}, 64'h1);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        check("bp_swap_valid", {56'd0, out_valid}, 64'h08);
        check("bp_swap_data", {56'd0, out_data[31:24]}, 64'h3C);

        // Other channels proceed while channel 3 stays stalled.
        drive(1'b1, 3'd0, 8'h11);
        #1 check("iso_ready0", {63'd0, in_ready}, 64'h1);
        drive(1'b1, 3'd7, 8'h22);
        #1 check("iso_ready7", {63'd0, in_ready}, 64'h1);
        check("iso_mid_valid", {56'd0, out_valid}, 64'h09);
        drive(1'b0, 3'd0, 8'h00);
        check("iso_valid", {56'd0, out_valid}, 64'h89);
        check("iso_data0", {56'd0, out_data[7:0]}, 64'h11);
        check("iso_data7", {56'd0, out_data[63:56]}, 64'h22);

        // Streaming with every consumer ready.
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            if (i > 0) begin
                check("stream_valid", {63'd0, out_valid[(i-1)%8]}, 64'h1);
                check("stream_data", {56'd0, out_data[((i-1)%8)*8 +: 8]}, 64'(i-1));
            end
            in_valid  = 1'b1;
            sel       = 3'(i % 8);
            in_data   = 8'(i);
            out_ready = 8'hFF;
            #1 check("stream_ready", {63'd0, in_ready}, 64'h1);
        end
        drive(1'b0, 3'd0, 8'h00);
        check("stream_last_data", {56'd0, out_data[63:56]}, 64'h0F);
        @(posedge clock);
        #1 check("stream_drained", {56'd0, out_valid}, 64'h0);

        // Random soak; a refused word is held until accepted.
        stall = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            stall = in_valid && !in_ready;
            @(posedge clock);
            #1;
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel      = 3'($urandom_range(0, 7));
                in_data  = 8'($urandom);
            end
            out_ready = 8'($urandom) & 8'($urandom | $urandom);
        end

        // Drain with a bounded wait.
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 8'hFF;
        left = 20;
        while (out_valid != 8'h00 && left > 0) begin
            @(posedge clock);
            #1;
            left--;
        end
        check("final_drain_valid", {56'd0, out_valid}, 64'h0);
        @(negedge clock);
        begin
            int total;
            total = 0;
            for (int i = 0; i < 8; i++) total += sb_q[i].size();
            check("final_scoreboard_empty", 64'(total), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
